unary_add_1_4_7: RTL and testbench

Serial unary (bit-stream) adder. In read mode it counts the 1-bits arriving on two serial streams A and B. In write mode it replays their saturated sum as a thermometer-coded stream on dout, and flags overflow on C. It sits between a serial stochastic/unary source and a serial consumer, one bit per clock.

---
 rtl/unary_add_1_4_7_pkg.sv | 20 ++
 rtl/unary_sat_counter.sv | 33 +++
 rtl/unary_add_1_4_7.sv | 101 ++++++++++
 tb/tb_unary_add_1_4_7.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/unary_add_1_4_7_pkg.sv
// Shared constants, mode encoding and saturating-add helper for the serial unary adder.
package unary_add_1_4_7_pkg;

  localparam int unsigned UNARY_N = 16;
  localparam int unsigned UNARY_W = $clog2(UNARY_N + 1);

  typedef enum logic {
    MODE_READ  = 1'b0,
    MODE_WRITE = 1'b1
  } mode_e;

  // min(x + y, cap); operands are far below 2^32 so the add cannot wrap.
  function automatic int unsigned sat_add(input int unsigned x, input int unsigned y,
                                          input int unsigned cap);
    int unsigned s;
    s = x + y;
    return (s > cap) ? cap : s;
  endfunction

endpackage

// File: rtl/unary_sat_counter.sv
// Up-counter that saturates at N, with synchronous clear taking priority over increment.
module unary_sat_counter
  import unary_add_1_4_7_pkg::*;
#(
  parameter int unsigned N = UNARY_N,
  parameter int unsigned W = UNARY_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  // Count enabled 1-bits, holding at N; clr wins so write entry empties the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (en) begin
      if (clr) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= W'(sat_add(32'(r_cnt), {31'b0, inc}, N));
      end
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/unary_add_1_4_7.sv
// Serial unary adder: counts 1-bits on A and B in read mode, then replays the saturated
// sum as a thermometer stream on dout in write mode, flagging overflow on C.
module unary_add_1_4_7
  import unary_add_1_4_7_pkg::*;
#(
  parameter int unsigned N = UNARY_N,
  parameter int unsigned W = $clog2(N + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic A,
  input  logic B,
  input  logic en,
  input  logic read_or_write,
  output logic dout,
  output logic C
);

  mode_e        w_mode;
  mode_e        r_mode_q;
  logic         w_entry;
  logic         w_inc_a;
  logic         w_inc_b;
  logic [W-1:0] w_cnt_a;
  logic [W-1:0] w_cnt_b;
  logic [W:0]   w_sum;
  logic         w_sum_over;
  logic [W-1:0] w_sum_sat;
  logic [W-1:0] r_out_cnt;
  logic         r_dout;
  logic         r_c;

  assign w_mode  = mode_e'(read_or_write);
  // First write edge after a read phase: latch the sum and empty the operand counters.
  assign w_entry = (w_mode == MODE_WRITE) && (r_mode_q == MODE_READ);
  // Operand bits are only sampled while reading.
  assign w_inc_a = A & (w_mode == MODE_READ);
  assign w_inc_b = B & (w_mode == MODE_READ);

  unary_sat_counter #(
    .N (N),
    .W (W)
  ) u_cnt_a (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (w_entry),
    .inc   (w_inc_a),
    .cnt   (w_cnt_a)
  );

  unary_sat_counter #(
    .N (N),
    .W (W)
  ) u_cnt_b (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (w_entry),
    .inc   (w_inc_b),
    .cnt   (w_cnt_b)
  );

  // Full-precision sum so overflow is detected on the saturated operand values.
  assign w_sum      = {1'b0, w_cnt_a} + {1'b0, w_cnt_b};
  assign w_sum_over = w_sum > (W + 1)'(N);
  assign w_sum_sat  = W'(sat_add(32'(w_cnt_a), 32'(w_cnt_b), N));

  // Mode tracking, output down-counter and registered dout/C.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_q  <= MODE_READ;
      r_out_cnt <= '0;
      r_dout    <= 1'b0;
      r_c       <= 1'b0;
    end else if (en) begin
      r_mode_q <= w_mode;
      if (w_mode == MODE_READ) begin
        // Any unfinished emission is abandoned on return to read.
        r_out_cnt <= '0;
        r_dout    <= 1'b0;
        if (r_mode_q == MODE_WRITE) begin
          r_c <= 1'b0;
        end
      end else if (r_mode_q == MODE_READ) begin
        r_out_cnt <= w_sum_sat;
        r_c       <= w_sum_over;
        r_dout    <= 1'b0;
      end else begin
        r_dout <= (r_out_cnt != '0);
        if (r_out_cnt != '0) begin
          r_out_cnt <= r_out_cnt - 1'b1;
        end
      end
    end
  end

  assign dout = r_dout;
  assign C    = r_c;

endmodule

// File: tb/tb_unary_add_1_4_7.sv
// Self-checking bench for unary_add_1_4_7: directed scenarios plus randomized traffic,
// compared against a phase-level reference model.
module tb_unary_add_1_4_7;

  localparam int N = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic A;
  logic B;
  logic en;
  logic rw;
  logic dout;
  logic C;

  int n_checks = 0;
  int n_pass   = 0;
  int ones_seen;

  // Reference model: true operand counts, emission length and edges since write entry.
  int m_ta, m_tb, m_len, m_j;
  bit m_mode, m_c, m_dout;

  unary_add_1_4_7 u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .A             (A),
    .B             (B),
    .en            (en),
    .read_or_write (rw),
    .dout          (dout),
    .C             (C)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic int min_i(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  task automatic model_reset();
    m_ta = 0; m_tb = 0; m_len = 0; m_j = 0;
    m_mode = 1'b0; m_c = 1'b0; m_dout = 1'b0;
  endtask

  task automatic model_step(input bit e, input bit r, input bit a, input bit b);
    int s;
    if (!e) return;
    if (!r) begin
      if (m_mode) begin
        m_ta = 0; m_tb = 0; m_c = 1'b0;
      end
      m_ta += a;
      m_tb += b;
      m_dout = 1'b0;
    end else if (!m_mode) begin
      s      = min_i(m_ta, N) + min_i(m_tb, N);
      m_len  = min_i(s, N);
      m_c    = (s > N);
      m_j    = 0;
      m_ta   = 0;
      m_tb   = 0;
      m_dout = 1'b0;
    end else begin
      m_j++;
      m_dout = (m_j <= m_len);
    end
    m_mode = r;
  endtask

  task automatic step(input bit e, input bit r, input bit a, input bit b, input string tag);
    @(negedge clk);
    en = e; rw = r; A = a; B = b;
    @(posedge clk);
    #1;
    model_step(e, r, a, b);
    check_eq({tag, ".dout"}, int'(dout), int'(m_dout));
    check_eq({tag, ".C"}, int'(C), int'(m_c));
    if (e && dout) ones_seen++;
  endtask

  task automatic read_n(input int n, input bit a, input bit b);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, a, b, "rd");
  endtask

  task automatic write_n(input int n);
    ones_seen = 0;
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'b0, "wr");
  endtask

  initial begin
    bit r_rand;
    rst_n = 1'b0; en = 1'b0; rw = 1'b0; A = 1'b0; B = 1'b0;
    model_reset();
    #12;
    check_eq("reset.dout", int'(dout), 0);
    check_eq("reset.C", int'(C), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sum 17 overflows: 16 ones, C=1.
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b1, (i != 7), "t1rd");
    write_n(20);
    check_eq("t1.ones", ones_seen, 16);
    check_eq("t1.C", int'(C), 1);

    // 3 + 4 = 7.
    read_n(3, 1'b1, 1'b1);
    read_n(1, 1'b0, 1'b1);
    write_n(12);
    check_eq("t2.ones", ones_seen, 7);
    check_eq("t2.C", int'(C), 0);

    // Zero sum.
    read_n(5, 1'b0, 1'b0);
    write_n(6);
    check_eq("t3.ones", ones_seen, 0);

    // A saturates at 16; 16 is not an overflow.
    read_n(20, 1'b1, 1'b0);
    write_n(20);
    check_eq("t4.ones", ones_seen, 16);
    check_eq("t4.C", int'(C), 0);

    // Sum 10 with a 3-cycle enable pause after the 4th output 1.
    read_n(5, 1'b1, 1'b1);
    write_n(5);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, "pause");
      check_eq("pause.hold", int'(dout), 1);
    end
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0, "wr");
    check_eq("t5.ones", ones_seen, 10);

    // Async reset mid-emission of an overflowing sum.
    read_n(12, 1'b1, 1'b1);
    write_n(5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rst.dout", int'(dout), 0);
    check_eq("rst.C", int'(C), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    read_n(2, 1'b1, 1'b0);
    write_n(6);
    check_eq("t6.ones", ones_seen, 2);

    // Return to read mid-emission.
    read_n(8, 1'b1, 1'b1);
    write_n(4);
    read_n(1, 1'b1, 1'b0);
    check_eq("abandon.C", int'(C), 0);
    write_n(5);
    check_eq("abandon.ones", ones_seen, 1);

    // Randomized traffic.
    r_rand = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) r_rand = ~r_rand;
      step(($urandom_range(0, 4) != 0), r_rand, 1'($urandom), 1'($urandom), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
